// File: rtl/vid_pkg.sv
// Shared types for the video-in to AXI-Stream bridge.
// Beat layout, FSM states and counter helpers.
package vid_pkg;
  localparam int CNT_W = 16;
  localparam int PIX_W = 24;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef enum logic [1:0] {
    WAIT_VS = 2'd0,
    ACTIVE  = 2'd1,
    RESYNC  = 2'd2
  } vid_state_e;

  typedef struct packed {
    logic             tuser;
    logic             tlast;
    logic [PIX_W-1:0] data;
  } vid_beat_t;

  localparam int BEAT_W = $bits(vid_beat_t);

  function automatic cnt_t sat_inc(cnt_t c);
    return (c == '1) ? c : c + cnt_t'(1);
  endfunction
endpackage

// File: rtl/vid_fwft_fifo.sv
// First-word-fall-through FIFO; head entry is visible while not empty.
// Simultaneous read and write is accepted even when full.
module vid_fwft_fifo
  import vid_pkg::*;
#(
  parameter int FIFO_AW = 5,
  parameter int W       = BEAT_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  output logic         full,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         empty
);
  localparam int DEPTH = 1 << FIFO_AW;

  logic [W-1:0]       mem [DEPTH];
  logic [FIFO_AW-1:0] wptr;
  logic [FIFO_AW-1:0] rptr;
  logic [FIFO_AW:0]   count;
  logic               do_wr;
  logic               do_rd;

  assign empty = (count == '0);
  assign full  = count[FIFO_AW];
  assign do_rd = rd_en & ~empty;
  assign do_wr = wr_en & (~full | do_rd);

  // Gate the head so the stream reads all-zero while empty.
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_wr) wptr <= wptr + FIFO_AW'(1);
      if (do_rd) rptr <= rptr + FIFO_AW'(1);
      unique case ({do_wr, do_rd})
        2'b10:   count <= count + (FIFO_AW+1)'(1);
        2'b01:   count <= count - (FIFO_AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr] <= wr_data;
  end
endmodule

// File: rtl/vid_in_axis.sv
// Video timing/pixel input to AXI4-Stream video bridge.
// Frame-locked FSM, geometry check and FWFT output buffer.
module vid_in_axis
  import vid_pkg::*;
#(
  parameter int VID_H_ACTIVE = 1280,
  parameter int VID_V_ACTIVE = 720,
  parameter int FIFO_AW      = 5
) (
  input  logic             PixelClk,
  input  logic             rst,
  input  logic             vid_pVDE,
  input  logic             vid_pHSync,
  input  logic             vid_pVSync,
  input  logic [PIX_W-1:0] vid_pData,
  output logic [PIX_W-1:0] m_axis_tdata,
  output logic             m_axis_tvalid,
  input  logic             m_axis_tready,
  output logic             m_axis_tuser,
  output logic             m_axis_tlast,
  output logic             locked,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_cnt
);
  localparam cnt_t H_EXP = cnt_t'(VID_H_ACTIVE);
  localparam cnt_t V_EXP = cnt_t'(VID_V_ACTIVE);

  vid_state_e       state;
  logic             s1_vde;
  logic             s1_hs;
  logic             s1_vs;
  logic             s1_vs_d;
  logic [PIX_W-1:0] s1_data;
  logic             hs_unused;
  logic             sof_pend;
  logic             line_err;
  cnt_t             h_cnt;
  cnt_t             v_cnt;

  logic      vs_rise;
  logic      eol;
  logic      pop;
  logic      push;
  logic      drop;
  logic      sof;
  logic      fifo_full;
  logic      fifo_empty;
  vid_beat_t wr_beat;
  vid_beat_t rd_beat;
  cnt_t      h_base;
  cnt_t      v_base;
  logic      err_base;
  cnt_t      h_inc;

  assign hs_unused = s1_hs;

  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      s1_vde  <= 1'b0;
      s1_hs   <= 1'b0;
      s1_vs   <= 1'b0;
      s1_vs_d <= 1'b0;
      s1_data <= '0;
    end else begin
      s1_vde  <= vid_pVDE;
      s1_hs   <= vid_pHSync;
      s1_vs   <= vid_pVSync;
      s1_vs_d <= s1_vs;
      s1_data <= vid_pData;
    end
  end

  assign vs_rise = s1_vs & ~s1_vs_d;
  assign eol     = s1_vde & ~vid_pVDE;
  assign pop     = m_axis_tvalid & m_axis_tready;
  assign push    = (state == ACTIVE) & s1_vde;
  assign drop    = push & fifo_full & ~pop;
  assign sof     = sof_pend | vs_rise;
  assign wr_beat = {sof, eol, s1_data};

  // A VSync edge starts a fresh frame; that cycle's pixel counts into it.
  assign h_base   = vs_rise ? '0 : h_cnt;
  assign v_base   = vs_rise ? '0 : v_cnt;
  assign err_base = vs_rise ? 1'b0 : line_err;
  assign h_inc    = sat_inc(h_base);

  always_ff @(posedge PixelClk or posedge rst) begin
    if (rst) begin
      state     <= WAIT_VS;
      sof_pend  <= 1'b0;
      line_err  <= 1'b0;
      h_cnt     <= '0;
      v_cnt     <= '0;
      locked    <= 1'b0;
      overflow  <= 1'b0;
      frame_cnt <= '0;
    end else begin
      unique case (state)
        WAIT_VS, RESYNC: begin
          if (state == RESYNC) locked <= 1'b0;
          if (vs_rise) begin
            state    <= ACTIVE;
            sof_pend <= 1'b1;
            line_err <= 1'b0;
            h_cnt    <= '0;
            v_cnt    <= '0;
          end
        end
        ACTIVE: begin
          if (vs_rise)
            locked <= ~line_err & (h_cnt == '0) & (v_cnt == V_EXP);
          if (drop) begin
            overflow <= 1'b1;
            locked   <= 1'b0;
            state    <= RESYNC;
          end else if (push) begin
            sof_pend <= 1'b0;
            if (sof) frame_cnt <= frame_cnt + cnt_t'(1);
            if (eol) begin
              h_cnt    <= '0;
              v_cnt    <= sat_inc(v_base);
              line_err <= err_base | (h_inc != H_EXP);
            end else begin
              h_cnt    <= h_inc;
              v_cnt    <= v_base;
              line_err <= err_base;
            end
          end else begin
            if (vs_rise) sof_pend <= 1'b1;
            h_cnt    <= h_base;
            v_cnt    <= v_base;
            line_err <= err_base;
          end
        end
        default: state <= WAIT_VS;
      endcase
    end
  end

  vid_fwft_fifo #(
    .FIFO_AW (FIFO_AW),
    .W       (BEAT_W)
  ) u_fifo (
    .clk     (PixelClk),
    .rst     (rst),
    .wr_en   (push & ~drop),
    .wr_data (wr_beat),
    .full    (fifo_full),
    .rd_en   (m_axis_tready),
    .rd_data (rd_beat),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = ~fifo_empty;
  assign m_axis_tdata  = rd_beat.data;
  assign m_axis_tuser  = rd_beat.tuser;
  assign m_axis_tlast  = rd_beat.tlast;
endmodule

// File: tb/tb_vid_in_axis.sv
// Directed bench for vid_in_axis with a beat scoreboard.
// Small 4x2 geometry so every scenario stays short.
module tb_vid_in_axis;
  localparam int H  = 4;
  localparam int V  = 2;
  localparam int AW = 5;

  logic        PixelClk = 1'b0;
  logic        rst = 1'b1;
  logic        vde = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [23:0] data = '0;
  logic [23:0] tdata;
  logic        tvalid;
  logic        tready = 1'b1;
  logic        tuser;
  logic        tlast;
  logic        locked;
  logic        overflow;
  logic [15:0] frame_cnt;

  int          vectors = 0;
  int          miscompares = 0;
  logic [25:0] sb[$];
  logic        toggle = 1'b0;
  logic        held_v = 1'b0;
  logic [25:0] held = '0;
  logic [25:0] want_b;

  vid_in_axis #(
    .VID_H_ACTIVE (H),
    .VID_V_ACTIVE (V),
    .FIFO_AW      (AW)
  ) dut (
    .PixelClk      (PixelClk),
    .rst           (rst),
    .vid_pVDE      (vde),
    .vid_pHSync    (hs),
    .vid_pVSync    (vs),
    .vid_pData     (data),
    .m_axis_tdata  (tdata),
    .m_axis_tvalid (tvalid),
    .m_axis_tready (tready),
    .m_axis_tuser  (tuser),
    .m_axis_tlast  (tlast),
    .locked        (locked),
    .overflow      (overflow),
    .frame_cnt     (frame_cnt)
  );

  always #5 PixelClk = ~PixelClk;

  always @(negedge PixelClk) begin
    if (rst) begin
      held_v = 1'b0;
    end else begin
      if (held_v) begin
        vectors++;
        assert ({tvalid, tuser, tlast, tdata} === {1'b1, held})
        else begin
          miscompares++;
          $error("FAIL stall_hold: got %0h expected %0h",
                 {tvalid, tuser, tlast, tdata}, {1'b1, held});
        end
      end
      if (tvalid && tready) begin
        vectors++;
        if (sb.size() == 0) begin
          miscompares++;
          $error("FAIL unexpected_beat: got %0h expected none",
                 {tuser, tlast, tdata});
        end else begin
          want_b = sb.pop_front();
          assert ({tuser, tlast, tdata} === want_b)
          else begin
            miscompares++;
            $error("FAIL beat: got %0h expected %0h",
                   {tuser, tlast, tdata}, want_b);
          end
        end
      end
      held_v = tvalid && !tready;
      held   = {tuser, tlast, tdata};
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] want);
    vectors++;
    assert (obs === want)
    else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic tick();
    @(posedge PixelClk);
    #1;
    if (toggle) tready = ~tready;
  endtask

  task automatic pix_line(input int n, input bit sof, input bit expect_out);
    for (int i = 0; i < n; i++) begin
      vde  = 1'b1;
      data = 24'($urandom);
      if (expect_out)
        sb.push_back({sof && (i == 0), i == n - 1, data});
      tick();
    end
    vde  = 1'b0;
    data = '0;
    tick();
    hs = 1'b1;
    tick();
    hs = 1'b0;
    tick();
  endtask

  task automatic frame(input int l0, input int l1, input bit expect_out);
    pix_line(l0, 1'b1, expect_out);
    pix_line(l1, 1'b0, expect_out);
  endtask

  task automatic vsync_pulse();
    vs = 1'b1;
    tick();
    tick();
    vs = 1'b0;
    tick();
    tick();
    tick();
  endtask

  task automatic wait_drain(input string tag);
    for (int i = 0; i < 200 && sb.size() != 0; i++) tick();
    check(tag, sb.size(), 0);
  endtask

  initial begin
    tick();
    tick();
    check("rst_tvalid", tvalid, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser_tlast", {tuser, tlast}, 0);
    check("rst_flags", {locked, overflow}, 0);
    check("rst_frame_cnt", frame_cnt, 0);
    rst = 1'b0;
    tick();

    // Pixels before the first VSync are ignored.
    pix_line(4, 1'b1, 1'b0);
    tick();
    check("wait_vs_no_out", tvalid, 0);

    // Nominal 4x2 frame.
    vsync_pulse();
    frame(4, 4, 1'b1);
    vsync_pulse();
    wait_drain("drain_nominal");
    check("locked_nominal", locked, 1);
    check("fcnt_nominal", frame_cnt, 1);

    // Short second... first line: geometry mismatch.
    frame(3, 4, 1'b1);
    vsync_pulse();
    wait_drain("drain_short");
    check("locked_short", locked, 0);
    check("fcnt_short", frame_cnt, 2);

    // Toggling tready; good geometry relocks.
    toggle = 1'b1;
    frame(4, 4, 1'b1);
    vsync_pulse();
    wait_drain("drain_toggle");
    toggle = 1'b0;
    tready = 1'b1;
    tick();
    check("locked_toggle", locked, 1);
    check("fcnt_toggle", frame_cnt, 3);

    // Overflow: 40-pixel line with tready held low.
    tready = 1'b0;
    vde = 1'b1;
    for (int i = 0; i < 40; i++) begin
      data = 24'($urandom);
      if (i < (1 << AW)) sb.push_back({i == 0, 1'b0, data});
      tick();
    end
    vde = 1'b0;
    tick();
    tick();
    check("ovf_set", overflow, 1);
    check("ovf_unlocked", locked, 0);
    check("ovf_fcnt", frame_cnt, 4);
    tready = 1'b1;
    wait_drain("drain_ovf");
    pix_line(4, 1'b0, 1'b0);
    tick();
    tick();
    check("resync_quiet", tvalid, 0);
    vsync_pulse();
    frame(4, 4, 1'b1);
    vsync_pulse();
    wait_drain("drain_recover");
    check("recover_locked", locked, 1);
    check("ovf_sticky", overflow, 1);
    check("recover_fcnt", frame_cnt, 5);

    // Reset mid-line with beats still buffered.
    tready = 1'b0;
    vde = 1'b1;
    data = 24'hABCDEF;
    tick();
    tick();
    tick();
    check("pre_rst_valid", tvalid, 1);
    rst = 1'b1;
    tick();
    check("mid_rst_tvalid", tvalid, 0);
    check("mid_rst_flags", {locked, overflow}, 0);
    check("mid_rst_fcnt", frame_cnt, 0);
    rst = 1'b0;
    tready = 1'b1;
    tick();
    tick();
    vde = 1'b0;
    tick();
    pix_line(4, 1'b0, 1'b0);
    check("post_rst_quiet", tvalid, 0);
    vsync_pulse();
    frame(4, 4, 1'b1);
    vsync_pulse();
    wait_drain("drain_post_rst");
    check("post_rst_locked", locked, 1);
    check("post_rst_fcnt", frame_cnt, 1);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end
endmodule
